// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if
// Groups the per-cycle hazard inputs from the pipeline stages and the
// stall/flush/bubble controls returned to them.
//
// Signalling: there is no valid/ready transfer on this interface. Every
// signal is a level that describes the current cycle. The pipeline presents
// stage status (id_*, ex_*, mm_*, imem_ready), and the controller replies
// combinationally in the same cycle. The pipeline registers sample those
// controls on the next rising clock edge.
//
// master : pipeline side (drives stage status, consumes controls)
// slave  : hazard controller side (consumes stage status, drives controls)
interface pipeline_ctrl_if;
  logic       id_valid;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       ex_valid;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic       ex_branch_taken;
  logic       mm_mem_req;
  logic       mm_mem_ready;
  logic       imem_ready;

  logic       pc_stall;
  logic       if_id_stall;
  logic       id_ex_stall;
  logic       ex_mm_stall;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       mm_wb_bubble;

  modport master (
    output id_valid, id_use_rs1, id_use_rs2, id_rs1, id_rs2,
    output ex_valid, ex_mem_read, ex_rd, ex_branch_taken,
    output mm_mem_req, mm_mem_ready, imem_ready,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mm_stall,
    input  if_id_flush, id_ex_flush, mm_wb_bubble
  );

  modport slave (
    input  id_valid, id_use_rs1, id_use_rs2, id_rs1, id_rs2,
    input  ex_valid, ex_mem_read, ex_rd, ex_branch_taken,
    input  mm_mem_req, mm_mem_ready, imem_ready,
    output pc_stall, if_id_stall, id_ex_stall, ex_mm_stall,
    output if_id_flush, id_ex_flush, mm_wb_bubble
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Hazard controller for a five-stage pipeline. It produces stall, flush and
// bubble controls in the same cycle as the hazard. A small FSM tracks
// data-memory waits and enforces a timeout. Two saturating counters record
// stall and branch-flush cycles.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   pif (slave)   : stage status in, pipeline controls out
//   perf_clr      : synchronous clear of stall_count / flush_count
//   state         : FSM state (0 = RUN, 1 = MEM_WAIT)
//   mem_timeout   : sticky flag, set when a memory wait hits MEM_TIMEOUT
//   stall_count   : cycles with pc_stall asserted (saturating)
//   flush_count   : cycles with a branch flush (saturating)
module pipeline_ctrl #(
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_ctrl_if.slave       pif,
  input  logic                 perf_clr,
  output logic [1:0]           state,
  output logic                 mem_timeout,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1
  } state_t;

  localparam logic [15:0]          TIMEOUT_VAL = 16'(MEM_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

  state_t      cur_state;
  logic [15:0] wait_cnt;

  logic mem_hold;
  logic load_use;
  logic in_wait;
  logic wait_expired;
  logic mem_stall;
  logic branch_flush;
  logic load_use_stall;
  logic imem_stall;

  always_comb begin
    mem_hold = pif.mm_mem_req && !pif.mm_mem_ready;
    load_use = pif.ex_valid && pif.ex_mem_read && (pif.ex_rd != 5'd0) && pif.id_valid &&
               ((pif.id_use_rs1 && (pif.id_rs1 == pif.ex_rd)) ||
                (pif.id_use_rs2 && (pif.id_rs2 == pif.ex_rd)));
    in_wait      = (cur_state == ST_MEM_WAIT);
    // In the cycle where the wait expires, the stalls are released. A bubble
    // is still injected into MM/WB, and nothing of lower priority may act,
    // because EX/MM still holds the abandoned access.
    wait_expired = in_wait && !pif.mm_mem_ready && (wait_cnt == TIMEOUT_VAL);
    mem_stall    = in_wait ? (!pif.mm_mem_ready && !wait_expired) : mem_hold;
    // A branch under a memory stall is ignored. EX is frozen, so the branch
    // is seen again once the stall releases.
    branch_flush   = !mem_stall && !wait_expired && pif.ex_branch_taken;
    load_use_stall = !mem_stall && !wait_expired && !pif.ex_branch_taken && load_use;
    imem_stall     = !mem_stall && !wait_expired && !pif.ex_branch_taken && !load_use &&
                     !pif.imem_ready;
  end

  always_comb begin
    pif.pc_stall     = 1'b0;
    pif.if_id_stall  = 1'b0;
    pif.id_ex_stall  = 1'b0;
    pif.ex_mm_stall  = 1'b0;
    pif.if_id_flush  = 1'b0;
    pif.id_ex_flush  = 1'b0;
    pif.mm_wb_bubble = 1'b0;
    if (rst_n) begin
      if (mem_stall) begin
        pif.pc_stall     = 1'b1;
        pif.if_id_stall  = 1'b1;
        pif.id_ex_stall  = 1'b1;
        pif.ex_mm_stall  = 1'b1;
        pif.mm_wb_bubble = 1'b1;
      end else if (wait_expired) begin
        pif.mm_wb_bubble = 1'b1;
      end else if (branch_flush) begin
        pif.if_id_flush  = 1'b1;
        pif.id_ex_flush  = 1'b1;
      end else if (load_use_stall) begin
        // Holding IF/ID while ID/EX takes a bubble gives exactly one bubble.
        // On the next cycle the load has moved on to MM.
        pif.pc_stall     = 1'b1;
        pif.if_id_stall  = 1'b1;
        pif.id_ex_flush  = 1'b1;
      end else if (imem_stall) begin
        pif.pc_stall     = 1'b1;
        pif.if_id_flush  = 1'b1;
      end
    end
  end

  // Memory-wait FSM. wait_cnt counts the cycles spent stalled on the current
  // access, including the RUN cycle that detected the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state   <= ST_RUN;
      wait_cnt    <= 16'd0;
      mem_timeout <= 1'b0;
    end else begin
      case (cur_state)
        ST_RUN: begin
          if (mem_hold) begin
            cur_state <= ST_MEM_WAIT;
            wait_cnt  <= 16'd1;
          end
        end
        ST_MEM_WAIT: begin
          if (pif.mm_mem_ready) begin
            cur_state <= ST_RUN;
            wait_cnt  <= 16'd0;
          end else if (wait_expired) begin
            cur_state   <= ST_RUN;
            wait_cnt    <= 16'd0;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: begin
          cur_state <= ST_RUN;
          wait_cnt  <= 16'd0;
        end
      endcase
    end
  end

  assign state = cur_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (perf_clr) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (pif.pc_stall && (stall_count != CNT_MAX)) stall_count <= stall_count + CNT_ONE;
      if (branch_flush && (flush_count != CNT_MAX)) flush_count <= flush_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
// Directed bench for pipeline_ctrl. A behavioural model keeps the memory-wait
// status and the two counters, and predicts the controls from the
// priority rules. A compare process checks the DUT against the model on
// every falling edge. Literal expectations in the stimulus pin the model.
module tb_pipeline_ctrl;
  localparam int CW  = 4;
  localparam int TO  = 4;
  localparam int SAT = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          perf_clr;
  logic [1:0]    state;
  logic          mem_timeout;
  logic [CW-1:0] stall_count;
  logic [CW-1:0] flush_count;

  pipeline_ctrl_if pif ();

  pipeline_ctrl #(.CNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pif         (pif),
    .perf_clr    (perf_clr),
    .state       (state),
    .mem_timeout (mem_timeout),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Output order: {pc, if_id_stall, id_ex_stall, ex_mm_stall, if_id_flush, id_ex_flush, bubble}
  localparam logic [6:0] O_MEM    = 7'b1111001;
  localparam logic [6:0] O_EXPIRE = 7'b0000001;
  localparam logic [6:0] O_BRANCH = 7'b0000110;
  localparam logic [6:0] O_LOADU  = 7'b1100010;
  localparam logic [6:0] O_IMEM   = 7'b1000100;

  bit m_waiting;   // a data-memory access has already stalled at least one cycle
  int m_waited;    // stalled cycles spent on that access so far
  bit m_to;
  int m_sc;
  int m_fc;

  function automatic logic [6:0] model_out();
    bit mh, lu, expired, mstall;
    if (!rst_n) return 7'b0;
    mh = pif.mm_mem_req && !pif.mm_mem_ready;
    lu = pif.ex_valid && pif.ex_mem_read && pif.ex_rd != 0 && pif.id_valid &&
         ((pif.id_use_rs1 && pif.id_rs1 == pif.ex_rd) || (pif.id_use_rs2 && pif.id_rs2 == pif.ex_rd));
    expired = m_waiting && !pif.mm_mem_ready && m_waited >= TO;
    mstall  = m_waiting ? (!pif.mm_mem_ready && !expired) : mh;
    if (mstall)               return O_MEM;
    if (expired)              return O_EXPIRE;
    if (pif.ex_branch_taken)  return O_BRANCH;
    if (lu)                   return O_LOADU;
    if (!pif.imem_ready)      return O_IMEM;
    return 7'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [6:0] o;
    if (!rst_n) begin
      m_waiting <= 1'b0;
      m_waited  <= 0;
      m_to      <= 1'b0;
      m_sc      <= 0;
      m_fc      <= 0;
    end else begin
      o = model_out();
      if (m_waiting) begin
        if (pif.mm_mem_ready) m_waiting <= 1'b0;
        else if (o == O_EXPIRE) begin
          m_waiting <= 1'b0;
          m_to      <= 1'b1;
        end else m_waited <= m_waited + 1;
      end else if (pif.mm_mem_req && !pif.mm_mem_ready) begin
        m_waiting <= 1'b1;
        m_waited  <= 1;
      end
      if (perf_clr) begin
        m_sc <= 0;
        m_fc <= 0;
      end else begin
        if (o[6] && m_sc < SAT)        m_sc <= m_sc + 1;
        if (o == O_BRANCH && m_fc < SAT) m_fc <= m_fc + 1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("ctrl_outs", {pif.pc_stall, pif.if_id_stall, pif.id_ex_stall, pif.ex_mm_stall,
                          pif.if_id_flush, pif.id_ex_flush, pif.mm_wb_bubble}, model_out());
      check("state", state, m_waiting ? 1 : 0);
      check("mem_timeout", mem_timeout, m_to);
      check("stall_count", stall_count, m_sc);
      check("flush_count", flush_count, m_fc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    pif.id_valid = 0; pif.id_use_rs1 = 0; pif.id_use_rs2 = 0;
    pif.id_rs1 = 0; pif.id_rs2 = 0;
    pif.ex_valid = 0; pif.ex_mem_read = 0; pif.ex_rd = 0; pif.ex_branch_taken = 0;
    pif.mm_mem_req = 0; pif.mm_mem_ready = 1; pif.imem_ready = 1;
    perf_clr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs2);
    pif.ex_valid = 1; pif.ex_mem_read = 1; pif.ex_rd = rd;
    pif.id_valid = 1; pif.id_use_rs2 = 1; pif.id_rs2 = rs2;
  endtask

  // Extra mixed vectors: {id_valid, use_rs1, use_rs2, rs1, rs2, ex_valid, mem_read, rd, branch, imem_ready}
  typedef struct packed {
    logic iv; logic u1; logic u2; logic [4:0] r1; logic [4:0] r2;
    logic ev; logic mr; logic [4:0] rd; logic br; logic im;
  } vec_t;
  vec_t vecs[6];

  initial begin
    idle();
    #2 rst_n = 0;
    // Hazards presented during reset must not reach the outputs.
    pif.mm_mem_req = 1; pif.mm_mem_ready = 0; pif.ex_branch_taken = 1; pif.imem_ready = 0;
    #1;
    check("rst_outs", {pif.pc_stall, pif.if_id_flush, pif.id_ex_flush, pif.mm_wb_bubble}, 0);
    check("rst_state", state, 0);
    check("rst_counts", {stall_count, flush_count, 3'b0, mem_timeout}, 0);
    cmp_en = 1;
    repeat (2) step();
    idle();
    rst_n = 1;

    // Load-use on rs2, then the same with rd = x0.
    step(); set_load_use(5, 5);
    @(negedge clk);
    check("lu_stall", {pif.pc_stall, pif.if_id_stall, pif.id_ex_flush, pif.id_ex_stall}, 4'b1110);
    step(); idle();
    @(negedge clk);
    check("lu_count", stall_count, 1);
    step(); set_load_use(0, 0);
    @(negedge clk);
    check("lu_x0", pif.pc_stall, 0);

    // Branch and load-use in the same cycle.
    step(); idle(); perf_clr = 1;
    step(); perf_clr = 0; set_load_use(7, 7); pif.ex_branch_taken = 1;
    @(negedge clk);
    check("br_lu", {pif.if_id_flush, pif.id_ex_flush, pif.pc_stall, pif.if_id_stall}, 4'b1100);
    step(); idle();
    @(negedge clk);
    check("br_count", {flush_count, stall_count}, {4'd1, 4'd0});

    // Memory wait of 3 cycles with a branch held in EX throughout.
    step(); pif.mm_mem_req = 1; pif.mm_mem_ready = 0; pif.ex_branch_taken = 1;
    @(negedge clk);
    check("mw_c1", {pif.pc_stall, pif.mm_wb_bubble, pif.if_id_flush, 2'(state)}, 5'b11000);
    step();
    @(negedge clk);
    check("mw_c2_state", state, 1);
    step();
    step(); pif.mm_mem_ready = 1;
    @(negedge clk);
    check("mw_c4", {pif.pc_stall, pif.mm_wb_bubble, pif.if_id_flush, 2'(state)}, 5'b00101);
    step(); idle();
    @(negedge clk);
    check("mw_after", {2'(state), flush_count}, {2'd0, 4'd2});

    // Timeout with MEM_TIMEOUT = 4.
    step(); pif.mm_mem_req = 1; pif.mm_mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("to_stall", pif.pc_stall, 1);
      step();
    end
    @(negedge clk);
    check("to_release", {pif.pc_stall, pif.ex_mm_stall, pif.mm_wb_bubble}, 3'b001);
    step(); idle();
    @(negedge clk);
    check("to_sticky", {2'(state), mem_timeout}, 3'b001);

    // Counter saturation and clear-over-increment.
    step(); perf_clr = 1;
    step(); perf_clr = 0; pif.imem_ready = 0;
    repeat (20) step();
    @(negedge clk);
    check("sat", stall_count, 15);
    step(); perf_clr = 1;
    step(); perf_clr = 0;
    @(negedge clk);
    check("clr_over_inc", stall_count, 0);
    step();
    @(negedge clk);
    check("inc_after_clr", stall_count, 1);

    // Reset during MEM_WAIT.
    step(); idle(); pif.mm_mem_req = 1; pif.mm_mem_ready = 0;
    step();
    check("rw_in_wait", state, 1);
    rst_n = 0;
    #1;
    check("rw_async", {2'(state), pif.pc_stall, pif.mm_wb_bubble, mem_timeout}, 0);
    @(negedge clk);
    step(); idle(); rst_n = 1;
    @(negedge clk);
    check("rw_release", {2'(state), pif.pc_stall}, 0);
    step(); pif.mm_mem_req = 1; pif.mm_mem_ready = 0;
    @(negedge clk);
    check("rw_rehold", pif.pc_stall, 1);
    step(); pif.mm_mem_ready = 1;
    step(); idle();

    // Mixed vectors, checked by the model alone.
    vecs[0] = '{1, 1, 0, 5'd3, 5'd0, 1, 1, 5'd3, 0, 1};  // load-use via rs1
    vecs[1] = '{1, 0, 0, 5'd3, 5'd3, 1, 1, 5'd3, 0, 1};  // sources not read
    vecs[2] = '{0, 1, 1, 5'd9, 5'd9, 1, 1, 5'd9, 0, 1};  // ID empty
    vecs[3] = '{1, 1, 1, 5'd4, 5'd4, 1, 0, 5'd4, 0, 0};  // not a load, imem stall
    vecs[4] = '{1, 1, 0, 5'd8, 5'd0, 1, 1, 5'd8, 0, 0};  // load-use beats imem
    vecs[5] = '{0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0};  // branch beats imem
    for (int i = 0; i < 6; i++) begin
      step();
      pif.id_valid = vecs[i].iv; pif.id_use_rs1 = vecs[i].u1; pif.id_use_rs2 = vecs[i].u2;
      pif.id_rs1 = vecs[i].r1; pif.id_rs2 = vecs[i].r2;
      pif.ex_valid = vecs[i].ev; pif.ex_mem_read = vecs[i].mr; pif.ex_rd = vecs[i].rd;
      pif.ex_branch_taken = vecs[i].br; pif.imem_ready = vecs[i].im;
    end
    step(); idle();
    repeat (2) step();
    cmp_en = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
